dnn_accel_system_pio_in: RTL and testbench



---
 rtl/dnn_accel_system_pio_in.sv | 91 +++++++++
 tb/tb_dnn_accel_system_pio_in.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dnn_accel_system_pio_in.sv
// Avalon-MM input PIO: synchronised WIDTH-bit input, per-bit edge capture (W1C)
// and, when PIO_IN_IRQ_EN is defined, a masked level interrupt.
module dnn_accel_system_pio_in #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int WARM = SYNC_STAGES + 1;
  localparam int CW   = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] data_in, data_d1, edges, edge_cap, irq_mask;
  logic [CW-1:0]    warm;
  logic             warm_done, wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign data_in      = sync[SYNC_STAGES-1];
  assign warm_done    = (warm == CW'(WARM));
  assign wr_en        = chipselect & write;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '0;
      data_d1 <= '0;
      warm    <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], in_port};
      data_d1 <= data_in;
      if (!warm_done) warm <= warm + 1'b1;
    end
  end

  // Edges are masked until the chain has refilled after reset, so an input
  // held high through reset does not look like a rising edge.
  always_comb begin
    if (EDGE_TYPE == 0)      edges = data_in & ~data_d1;
    else if (EDGE_TYPE == 1) edges = ~data_in & data_d1;
    else                     edges = data_in ^ data_d1;
    if (!warm_done) edges = '0;
  end

  // New edges are OR-ed in after the clear, so set wins over write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset)
      edge_cap <= '0;
    else if (wr_en && address == 2'd3)
      edge_cap <= (edge_cap & ~writedata[WIDTH-1:0]) | edges;
    else
      edge_cap <= edge_cap | edges;
  end

`ifdef PIO_IN_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)
      irq_mask <= '0;
    else if (wr_en && address == 2'd2)
      irq_mask <= writedata[WIDTH-1:0];
  end
  assign irq = |(edge_cap & irq_mask);
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = data_in;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end
endmodule

// File: tb/tb_dnn_accel_system_pio_in.sv
// Scoreboard bench for dnn_accel_system_pio_in: a rising-edge and an any-edge
// instance share one bus; expected read data is queued when a read is issued.
module tb_dnn_accel_system_pio_in;
`ifdef PIO_IN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write;
  logic [31:0] writedata;
  logic [6:0]  in_port, in_port2;
  logic [31:0] readdata, readdata2;
  logic        irq, irq2;

  logic [31:0] exp_q[$];
  logic [31:0] got, e;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dnn_accel_system_pio_in #(.WIDTH(7), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq));

  dnn_accel_system_pio_in #(.WIDTH(7), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    address = a;
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0;
    writedata = '0; in_port = 7'h7F; in_port2 = 7'h00;
    tick(3);
    n_chk++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq); end
    reset = 1'b0;
    tick(4);
    rd(2'd0, 32'h7F); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL rst_data got=%h exp=%h", got, e); end
    rd(2'd3, 32'h0); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL rst_no_capture got=%h exp=%h", got, e); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq_after got=%b exp=0", irq); end
  endtask

  task automatic test_rising;
    in_port = 7'h00; tick(4);
    wr(2'd3, 32'h7F);
    in_port = 7'h05;
    for (int i = 0; i < 3; i++) begin
      rd(2'd3, 32'h0); got = readdata; e = exp_q.pop_front();
      n_chk++; if (got !== e) begin n_fail++; $display("FAIL rise_early%0d got=%h exp=%h", i, got, e); end
    end
    rd(2'd3, 32'h05); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL rise_capture got=%h exp=%h", got, e); end
    in_port = 7'h00; tick(4);
    rd(2'd3, 32'h05); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL rise_sticky got=%h exp=%h", got, e); end
  endtask

  task automatic test_irq;
    wr(2'd2, 32'h04);
    rd(2'd2, IRQ_EN ? 32'h04 : 32'h0); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL irq_mask_rd got=%h exp=%h", got, e); end
    wr(2'd3, 32'h7F);
    in_port = 7'h01; tick(4);
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_unmasked got=%b exp=0", irq); end
    in_port = 7'h05; tick(4);
    n_chk++; if (irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_masked got=%b exp=%b", irq, IRQ_EN); end
    wr(2'd3, 32'h04);
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq); end
    rd(2'd3, 32'h01); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL irq_cap_left got=%h exp=%h", got, e); end
  endtask

  task automatic test_set_clear;
    in_port = 7'h07;
    tick(2);
    wr(2'd3, 32'h02);
    rd(2'd3, 32'h03); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL set_wins got=%h exp=%h", got, e); end
    wr(2'd3, 32'h02);
    rd(2'd3, 32'h01); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL w1c got=%h exp=%h", got, e); end
  endtask

  task automatic test_any_edge;
    in_port2 = 7'h40; tick(4);
    rd(2'd3, 32'h40); got = readdata2; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL any_rise got=%h exp=%h", got, e); end
    wr(2'd3, 32'h7F);
    rd(2'd3, 32'h0); got = readdata2; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL any_clr got=%h exp=%h", got, e); end
    in_port2 = 7'h00; tick(4);
    rd(2'd3, 32'h40); got = readdata2; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL any_fall got=%h exp=%h", got, e); end
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL addr1_a got=%h exp=%h", got, e); end
    rd(2'd1, 32'h0); got = readdata2; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL addr1_b got=%h exp=%h", got, e); end
    rd(2'd0, 32'h0000_0007); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL data_upper got=%h exp=%h", got, e); end
  endtask

  task automatic test_irq_cfg_and_reset;
    wr(2'd2, 32'h7F);
    rd(2'd2, IRQ_EN ? 32'h7F : 32'h0); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL mask_cfg got=%h exp=%h", got, e); end
    in_port = 7'h17; tick(4);
    rd(2'd3, 32'h10); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL cfg_capture got=%h exp=%h", got, e); end
    n_chk++; if (irq !== IRQ_EN) begin n_fail++; $display("FAIL cfg_irq got=%b exp=%b", irq, IRQ_EN); end
    reset = 1'b1; address = 2'd2; writedata = 32'h7F; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    n_chk++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rd got=%h exp=0", readdata); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq got=%b exp=0", irq); end
    reset = 1'b0;
    tick(4);
    rd(2'd3, 32'h0); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL mid_rst_cap got=%h exp=%h", got, e); end
    rd(2'd2, 32'h0); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL mid_rst_mask got=%h exp=%h", got, e); end
    rd(2'd0, 32'h17); got = readdata; e = exp_q.pop_front();
    n_chk++; if (got !== e) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=%h", got, e); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq_after got=%b exp=0", irq); end
  endtask

  initial begin
    test_reset;
    test_rising;
    test_irq;
    test_set_clear;
    test_any_edge;
    test_irq_cfg_and_reset;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
